alu_result_serializer: RTL and testbench
========================================

// Module: alu_result_serializer
// PURPOSE
//   Downstream stage of the FSM-ALU top. Captures each ALU result (res, CF, GZ) on a valid strobe.
//   Buffers results in a small FIFO.
//   Transmits each one as a framed, even-parity serial word on a single tx line, for off-chip observation.
//   Decouples the ALU issue rate from the slow serial link; reports overflow when results are dropped.
// PARAMETERS
//   DATA_W   7  width of ALU result res_in
//   DEPTH    4  FIFO entries (power of 2, >=2)
//   BAUD_DIV 4  clk cycles per serial bit (>=1)
// PORTS
//   clk         in   1                 system clock, rising edge
//   rst         in   1                 asynchronous, active-low reset
//   res_in      in   DATA_W            ALU result
//   cf_in       in   1                 ALU carry flag
//   gz_in       in   1                 ALU greater-than-zero flag
//   res_valid   in   1                 1-cycle strobe: res_in/cf_in/gz_in valid this cycle
//   clr_ovf     in   1                 clears sticky overflow
//   tx          out  1                 serial output, idle high
//   tx_busy     out  1                 high while a frame is on tx (START..STOP)
//   fifo_count  out  $clog2(DEPTH)+1   entries held
//   fifo_full   out  1                 fifo_count==DEPTH
//   fifo_empty  out  1                 fifo_count==0
//   overflow    out  1                 sticky: a result was dropped
// BEHAVIOUR
//   Reset (rst=0, async): tx=1, tx_busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0.
//     Pointers cleared, FSM=IDLE. Applies immediately, mid-frame included; the FIFO is flushed.
//   Word packing: W[DATA_W+1:0] = {gz_in, cf_in, res_in} (9 bits by default).
//   Push: a clk edge with res_valid=1 writes W if not full, or if full and a pop occurs the same edge.
//     Otherwise W is dropped and overflow<=1.
//   overflow: set has priority over clr_ovf in the same cycle; clr_ovf alone clears it next edge.
//   Pop happens only in IDLE with fifo non-empty. The head entry is loaded into the shift register at that edge.
//     The FSM then enters START. Simultaneous push+pop leaves count unchanged.
//   FSM (each non-IDLE state holds BAUD_DIV cycles, bit counter inside DATA):
//     IDLE   tx=1, busy=0; -> START on pop
//     START  tx=0                                   -> DATA
//     DATA   tx=W[i], i=0..DATA_W+1, LSB first      -> PARITY after last bit
//     PARITY tx=^W (even parity: total ones incl. parity even) -> STOP
//     STOP   tx=1                                   -> IDLE (always)
//   Frame = 1+(DATA_W+2)+1+1 = 12 bits = 12*BAUD_DIV cycles. At least 1 IDLE cycle between frames.
//   Latency: push at edge N -> fifo_empty=0 after N; pop at N+1; tx=0 after N+1 (first start cycle).
//   tx_busy=1 for all START..STOP cycles. tx and tx_busy are registered outputs.
//   fifo_count/full/empty are registered and update at the edge of the push/pop.
//   Inputs are sampled only when res_valid=1. Word order on tx equals push order.
//   Pointers wrap modulo DEPTH; full/empty are derived from the count, not from pointer equality.
// TESTING (BAUD_DIV=4, DEPTH=4)
//   1. res=42,cf=0,gz=1 single push -> W=9'h12A.
//      tx per 4-cycle bit: 0|0,1,0,1,0,1,0,0,1|0|1, then tx=1 idle, busy low after 48 cycles.
//   2. Parity corners -> res=0,cf=0,gz=0: parity 0; res=127,cf=1,gz=0: parity 0; res=127,cf=1,gz=1: parity 1.
//   3. Six consecutive res_valid pushes (values 1..6) from idle.
//      First pops at next edge; fifo_full=1 after push 5; push 6 dropped, overflow=1.
//      Frames carry 1..5 in order.
//   4. FIFO full in IDLE, push on the same edge as pop -> push accepted, count stays 4, overflow stays 0.
//   5. Push while overflow=1, with clr_ovf=1 on the same edge -> overflow stays 1.
//      clr_ovf alone the next cycle -> overflow=0.
//   6. rst=0 mid-DATA of a frame with 2 entries queued -> tx=1, busy=0, count=0 immediately.
//      After release, no frame is emitted until a new push.

Source files
------------

// File: rtl/alu_result_serializer.sv
// Buffers ALU results (res, CF, GZ) in a small FIFO and sends each one on tx as a framed word:
// start bit, data bits LSB first, even-parity bit, stop bit.
module alu_result_serializer #(
  parameter int unsigned DATA_W   = 7,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        res_in,
  input  logic                     cf_in,
  input  logic                     gz_in,
  input  logic                     res_valid,
  input  logic                     clr_ovf,
  output logic                     tx,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     overflow
);

  localparam int unsigned WordW = DATA_W + 2;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BitW  = $clog2(WordW);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WordW - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // FIFO storage and bookkeeping
  logic [WordW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             ovf_q, ovf_d;

  // Transmitter state
  logic [2:0]       state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WordW-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic             push, pop, drop, bit_end;
  logic [WordW-1:0] word_in, head;

  assign word_in = {gz_in, cf_in, res_in};
  assign head    = mem_q[rd_ptr_q];
  assign pop     = (state_q == StIdle) && !empty_q;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push    = res_valid && (!full_q || pop);
  assign drop    = res_valid && !push;
  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CntFull);
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + BaudW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          baud_d  = '0;
          bit_d   = '0;
          shreg_d = head;
          par_d   = ^head;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == BitLast) begin
            state_d = StParity;
          end else begin
            bit_d   = bit_q + BitW'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
      end
    endcase
  end

  // tx is registered, so it is decoded from the state being entered.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: a table of single-word frames plus hand-written
// sequences for FIFO fill/overflow, push-on-pop at full, and mid-frame reset.
module tb_alu_result_serializer;

  localparam int unsigned DATA_W   = 7;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned BAUD_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] res_in = '0;
  logic              cf_in = 1'b0;
  logic              gz_in = 1'b0;
  logic              res_valid = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              tx, tx_busy, fifo_full, fifo_empty, overflow;
  logic [2:0]        fifo_count;

  int n_vec = 0;
  int n_bad = 0;

  // frame[k] is the k-th bit on tx: {stop, parity, W[8:0], start}
  typedef struct packed {
    logic [6:0]  res;
    logic        cf;
    logic        gz;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs [6];

  alu_result_serializer #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .BAUD_DIV(BAUD_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .res_in    (res_in),
    .cf_in     (cf_in),
    .gz_in     (gz_in),
    .res_valid (res_valid),
    .clr_ovf   (clr_ovf),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Current time is 'at' edges after the frame's first start cycle; sample mid-bit from first_k.
  task automatic grab(input int first_k, input int at, output logic [11:0] f);
    int pos;
    pos = at;
    f = '0;
    for (int k = first_k; k < 12; k++) begin
      while (pos < 4 * k + 2) begin
        tick();
        pos++;
      end
      f[k] = tx;
    end
  endtask

  task automatic wait_start(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (tx === 1'b0) found = 1'b1;
      else tick();
    end
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    logic [11:0] f;
    res_in = v.res; cf_in = v.cf; gz_in = v.gz; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check($sformatf("v%0d_empty_after_push", idx), fifo_empty, 0);
    check($sformatf("v%0d_count_after_push", idx), fifo_count, 1);
    check($sformatf("v%0d_tx_still_idle", idx), tx, 1);
    tick();
    check($sformatf("v%0d_start_tx", idx), tx, 0);
    check($sformatf("v%0d_start_busy", idx), tx_busy, 1);
    check($sformatf("v%0d_count_after_pop", idx), fifo_count, 0);
    grab(0, 0, f);
    check($sformatf("v%0d_frame", idx), f, v.frame);
    tick();
    check($sformatf("v%0d_busy_last_cycle", idx), tx_busy, 1);
    tick();
    check($sformatf("v%0d_busy_end", idx), tx_busy, 0);
    check($sformatf("v%0d_tx_idle", idx), tx, 1);
    tick();
  endtask

  initial begin
    logic [11:0] f;
    logic        sbit;
    bit          found;
    logic [11:0] exp3 [6];
    logic [11:0] exp4 [5];

    vecs[0] = '{res: 7'd42,  cf: 1'b0, gz: 1'b1, frame: 12'hA54};
    vecs[1] = '{res: 7'd0,   cf: 1'b0, gz: 1'b0, frame: 12'h800};
    vecs[2] = '{res: 7'd127, cf: 1'b1, gz: 1'b0, frame: 12'h9FE};
    vecs[3] = '{res: 7'd127, cf: 1'b1, gz: 1'b1, frame: 12'hFFE};
    vecs[4] = '{res: 7'd85,  cf: 1'b0, gz: 1'b1, frame: 12'hEAA};
    vecs[5] = '{res: 7'd1,   cf: 1'b1, gz: 1'b0, frame: 12'h902};
    exp3 = '{12'h000, 12'hC02, 12'hC04, 12'h806, 12'hC08, 12'h80A};
    exp4 = '{12'hC16, 12'h818, 12'hC1A, 12'hC1C, 12'h81E};

    #1 rst = 1'b0;
    #2;
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

    // Six back-to-back pushes, then a dropped push with clr_ovf, then clr_ovf alone.
    sbit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      res_valid = (i < 7);
      res_in    = 7'(i + 1);
      cf_in     = 1'b0;
      gz_in     = 1'b0;
      clr_ovf   = (i >= 6);
      tick();
      if (i == 0) check("burst_count0", fifo_count, 1);
      if (i == 1) check("burst_first_start", tx, 0);
      if (i == 1) check("burst_count1", fifo_count, 1);
      if (i == 3) sbit = tx;
      if (i == 3) check("burst_count3", fifo_count, 3);
      if (i == 4) check("burst_full", fifo_full, 1);
      if (i == 4) check("burst_no_ovf_yet", overflow, 0);
      if (i == 5) check("burst_ovf", overflow, 1);
      if (i == 5) check("burst_count_held", fifo_count, 4);
      if (i == 6) check("ovf_set_beats_clr", overflow, 1);
      if (i == 7) check("ovf_cleared", overflow, 0);
    end
    res_valid = 1'b0;
    clr_ovf   = 1'b0;
    grab(1, 6, f);
    f[0] = sbit;
    check("burst_frame1", f, exp3[1]);
    for (int k = 2; k <= 5; k++) begin
      wait_start(100, found);
      check($sformatf("burst_start%0d", k), found, 1);
      grab(0, 0, f);
      check($sformatf("burst_frame%0d", k), f, exp3[k]);
    end
    wait_start(80, found);
    check("burst_no_extra_frame", found, 0);
    check("burst_drained", fifo_empty, 1);

    // Fill to 4 during a frame, then push on the very edge the next pop happens.
    for (int i = 0; i < 5; i++) begin
      res_in = 7'(10 + i); res_valid = 1'b1;
      tick();
    end
    res_valid = 1'b0;
    repeat (45) tick();
    check("full_idle_busy", tx_busy, 0);
    check("full_idle_count", fifo_count, 4);
    res_in = 7'd15; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("pushpop_count", fifo_count, 4);
    check("pushpop_full", fifo_full, 1);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_start", tx, 0);
    grab(0, 0, f);
    check("pushpop_frame11", f, exp4[0]);
    for (int k = 1; k < 5; k++) begin
      wait_start(100, found);
      check($sformatf("pushpop_start%0d", k), found, 1);
      grab(0, 0, f);
      check($sformatf("pushpop_frame%0d", k), f, exp4[k]);
    end
    repeat (4) tick();

    // Reset mid-DATA with two entries queued.
    for (int i = 0; i < 3; i++) begin
      res_in = (i == 2) ? 7'd3 : 7'd0; res_valid = 1'b1;
      tick();
    end
    res_valid = 1'b0;
    repeat (9) tick();
    check("mid_data_tx", tx, 0);
    check("mid_data_count", fifo_count, 2);
    rst = 1'b0;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", tx_busy, 0);
    check("async_rst_count", fifo_count, 0);
    check("async_rst_empty", fifo_empty, 1);
    tick();
    rst = 1'b1;
    wait_start(100, found);
    check("no_frame_after_rst", found, 0);
    check("idle_busy_after_rst", tx_busy, 0);
    run_vector(vecs[0], 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
